fsmc_mem_bridge: RTL and testbench

Upstream stage of the frame buffer memory. Converts the asynchronous FSMC strobes from the MCU into single-clock memory accesses. Drives the buffer's READ_WRITE, COLUMN_ADDR, ROW_ADDR and IN_DATA, and returns its registered OUT_DATA to the FSMC data bus. Guarantees READ_WRITE is low for exactly one CLK per committed write; the buffer writes on every cycle that READ_WRITE is 0.

---
 rtl/fsmc_mem_bridge.sv | 183 ++++++++++++++++++
 tb/tb_fsmc_mem_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_mem_bridge.sv
// FSMC strobe-to-buffer bridge: synchronises MCU strobes and issues single-CLK buffer accesses.
// Optional macro FSMC_STAT_EN adds saturating WR_COUNT / RD_COUNT outputs.
`timescale 1ns/1ps
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif
`ifndef LENTH_BUFER
`define LENTH_BUFER 4096
`endif

module fsmc_mem_bridge #(
    parameter int unsigned DATA_W  = `FSMC_WIDTH,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned BUF_LEN = `LENTH_BUFER
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FSMC_NE,
    input  logic              FSMC_NOE,
    input  logic              FSMC_NWE,
    input  logic [ADDR_W-1:0] FSMC_A,
    input  logic [DATA_W-1:0] FSMC_D_IN,
    output logic [DATA_W-1:0] FSMC_D_OUT,
    output logic              FSMC_D_OE,
    output logic              MEM_READ_WRITE,
    output logic [15:0]       MEM_COLUMN_ADDR,
    output logic [15:0]       MEM_ROW_ADDR,
    output logic [DATA_W-1:0] MEM_IN_DATA,
    input  logic [DATA_W-1:0] MEM_OUT_DATA,
    output logic              BUSY,
    output logic              ERR
`ifdef FSMC_STAT_EN
    ,
    output logic [15:0]       WR_COUNT,
    output logic [15:0]       RD_COUNT
`endif
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_WAIT, WR_COMMIT, HOLD} state_t;

    state_t              state_q, state_d;
    logic                ne_p1, noe_p1, nwe_p1, ne_s, noe_s, nwe_s;
    logic [ADDR_W-1:0]   a_p1, a_s;
    logic [DATA_W-1:0]   d_p1, d_s;
    logic                rw_q, rw_d, oe_q, oe_d, err_q, err_d, busy_q;
    logic                rd_first_q, rd_first_d;
    logic [15:0]         col_q, col_d, row_q;
    logic [DATA_W-1:0]   in_q, in_d, dout_q, dout_d;
    logic                rd_hold;

    assign rd_hold = !ne_s && !noe_s;

    // Two-stage synchronisers; address and data share the strobe latency.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ne_p1  <= 1'b1;  ne_s  <= 1'b1;
            noe_p1 <= 1'b1;  noe_s <= 1'b1;
            nwe_p1 <= 1'b1;  nwe_s <= 1'b1;
            a_p1   <= '0;    a_s   <= '0;
            d_p1   <= '0;    d_s   <= '0;
        end else begin
            ne_p1  <= FSMC_NE;   ne_s  <= ne_p1;
            noe_p1 <= FSMC_NOE;  noe_s <= noe_p1;
            nwe_p1 <= FSMC_NWE;  nwe_s <= nwe_p1;
            a_p1   <= FSMC_A;    a_s   <= a_p1;
            d_p1   <= FSMC_D_IN; d_s   <= d_p1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!ne_s) begin
                    if (!noe_s && nwe_s)       state_d = RD_ADDR;
                    else if (noe_s && !nwe_s)  state_d = WR_WAIT;
                    else if (!noe_s && !nwe_s) state_d = HOLD;
                end
            end
            RD_ADDR:   state_d = RD_DATA;
            RD_DATA:   if (!rd_hold) state_d = IDLE;
            WR_WAIT:   if (nwe_s || ne_s) state_d = WR_COMMIT;
            WR_COMMIT: state_d = IDLE;
            HOLD:      if (ne_s && noe_s && nwe_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the write strobe is decided on entry to WR_COMMIT.
    always_comb begin
        col_d      = col_q;
        in_d       = in_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        err_d      = 1'b0;
        rw_d       = 1'b1;
        rd_first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_d == RD_ADDR) col_d = 16'(a_s);
                if (state_d == HOLD)    err_d = 1'b1;
            end
            RD_ADDR: rd_first_d = 1'b1;
            RD_DATA: begin
                if (!rd_hold) begin
                    oe_d = 1'b0;
                end else if (rd_first_q) begin
                    oe_d   = 1'b1;
                    dout_d = (32'(col_q) < BUF_LEN) ? MEM_OUT_DATA : '0;
                end
            end
            WR_WAIT: begin
                if (!nwe_s) begin
                    in_d  = d_s;
                    col_d = 16'(a_s);
                end
                if (state_d == WR_COMMIT) rw_d = (32'(col_d) < BUF_LEN) ? 1'b0 : 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rw_q       <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            in_q       <= '0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            rw_q       <= rw_d;
            col_q      <= col_d;
            row_q      <= '0;
            in_q       <= in_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
            rd_first_q <= rd_first_d;
        end
    end

    assign MEM_READ_WRITE  = rw_q;
    assign MEM_COLUMN_ADDR = col_q;
    assign MEM_ROW_ADDR    = row_q;
    assign MEM_IN_DATA     = in_q;
    assign FSMC_D_OUT      = dout_q;
    assign FSMC_D_OE       = oe_q;
    assign BUSY            = busy_q;
    assign ERR             = err_q;

`ifdef FSMC_STAT_EN
    logic        wr_inc_c, rd_inc_c;
    logic [15:0] wr_cnt_q, rd_cnt_q;

    assign wr_inc_c = (state_q == WR_WAIT) && (state_d == WR_COMMIT) && !rw_d;
    assign rd_inc_c = (state_q == RD_ADDR);

    // Saturating access counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_inc_c && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd_inc_c && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign WR_COUNT = wr_cnt_q;
    assign RD_COUNT = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fsmc_mem_bridge.sv
// Directed bench for fsmc_mem_bridge: a full-size instance and a BUF_LEN=16 instance share one
// FSMC stimulus; a buffer model and a transaction-level scoreboard supply all expectations.
`timescale 1ns/1ps

module tb_fsmc_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ne, noe, nwe;
    logic [11:0] a;
    logic [15:0] din;
    logic [15:0] dout, s_dout, min, s_min, col, s_col, row, s_row, mem_out;
    logic        oe, s_oe, rw, s_rw, busy, s_busy, err, s_err;
`ifdef FSMC_STAT_EN
    logic [15:0] wrc, rdc, s_wrc, s_rdc;
`endif

    always #5 clk = ~clk;

    fsmc_mem_bridge u_dut (
        .CLK(clk), .RESET(rst), .FSMC_NE(ne), .FSMC_NOE(noe), .FSMC_NWE(nwe),
        .FSMC_A(a), .FSMC_D_IN(din), .FSMC_D_OUT(dout), .FSMC_D_OE(oe),
        .MEM_READ_WRITE(rw), .MEM_COLUMN_ADDR(col), .MEM_ROW_ADDR(row),
        .MEM_IN_DATA(min), .MEM_OUT_DATA(mem_out), .BUSY(busy), .ERR(err)
`ifdef FSMC_STAT_EN
        , .WR_COUNT(wrc), .RD_COUNT(rdc)
`endif
    );

    fsmc_mem_bridge #(.BUF_LEN(16)) u_small (
        .CLK(clk), .RESET(rst), .FSMC_NE(ne), .FSMC_NOE(noe), .FSMC_NWE(nwe),
        .FSMC_A(a), .FSMC_D_IN(din), .FSMC_D_OUT(s_dout), .FSMC_D_OE(s_oe),
        .MEM_READ_WRITE(s_rw), .MEM_COLUMN_ADDR(s_col), .MEM_ROW_ADDR(s_row),
        .MEM_IN_DATA(s_min), .MEM_OUT_DATA(mem_out), .BUSY(s_busy), .ERR(s_err)
`ifdef FSMC_STAT_EN
        , .WR_COUNT(s_wrc), .RD_COUNT(s_rdc)
`endif
    );

    // Frame buffer: writes while READ_WRITE is 0, OUT_DATA registered one CLK after the address.
    logic [15:0] bufmem [0:4095];
    always @(posedge clk) begin
        if (rw === 1'b0) bufmem[col[11:0]] <= min;
        mem_out <= bufmem[col[11:0]];
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wq[$];
    logic [15:0] ref_mem [0:4095];
    int checks = 0, errors = 0;
    int exp_commits = 0, exp_small = 0, exp_reads = 0;
    int main_lows = 0, small_lows = 0, err_pulses = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Per-cycle scoreboard: every write strobe must match the oldest expected transaction.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("row_addr", row, 0);
            chk("small_row_addr", s_row, 0);
            if (rw === 1'b0) begin
                main_lows++;
                chk("write_expected", 32'(exp_wq.size() > 0), 1);
                if (exp_wq.size() > 0) begin
                    wr_t e;
                    e = exp_wq.pop_front();
                    chk("wr_addr", col, e.addr);
                    chk("wr_data", min, e.data);
                end
            end
            if (s_rw === 1'b0) small_lows++;
            if (err === 1'b1) err_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rw"}, rw, 1);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_in"}, min, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_oe"}, oe, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [15:0] d1, input int n1,
                      input logic [15:0] d2, input int n2);
        int lat, lat_s;
        a = addr; din = d1; ne = 1'b0; nwe = 1'b0;
        tick(n1);
        din = d2;
        if (n2 > 0) tick(n2);
        ne = 1'b1; nwe = 1'b1;
        exp_wq.push_back('{16'(addr), d2});
        ref_mem[addr] = d2;
        exp_commits++;
        if (addr < 12'd16) exp_small++;
        lat = 0; lat_s = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #3;
            if (rw === 1'b0 && lat == 0) lat = i;
            if (s_rw === 1'b0 && lat_s == 0) lat_s = i;
        end
        chk("wr_latency", lat, 3);
        chk("wr_small_latency", lat_s, (addr < 12'd16) ? 3 : 0);
        chk("wr_queue_drained", exp_wq.size(), 0);
        tick(2);
    endtask

    task automatic rd(input logic [11:0] addr);
        int lat_on, lat_off;
        a = addr; ne = 1'b0; noe = 1'b0;
        exp_reads++;
        lat_on = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #3;
            if (oe === 1'b1 && lat_on == 0) begin
                lat_on = i;
                chk("rd_data", dout, ref_mem[addr]);
                chk("rd_small_data", s_dout, (addr < 12'd16) ? ref_mem[addr] : 16'h0000);
            end
        end
        chk("rd_latency", lat_on, 5);
        chk("rd_oe_held", oe, 1);
        ne = 1'b1; noe = 1'b1;
        lat_off = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #3;
            if (oe === 1'b0 && lat_off == 0) lat_off = i;
        end
        chk("rd_release_within_3", 32'(lat_off >= 1 && lat_off <= 3), 1);
        tick(2);
    endtask

    task automatic proto_err();
        int first, nerr, lat_idle;
        ne = 1'b0; noe = 1'b0; nwe = 1'b0;
        first = 0; nerr = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #3;
            chk("err_no_drive", oe, 0);
            if (err === 1'b1) begin
                nerr++;
                if (first == 0) first = i;
            end
        end
        chk("err_latency", first, 3);
        chk("err_width", nerr, 1);
        chk("err_busy", busy, 1);
        ne = 1'b1; noe = 1'b1; nwe = 1'b1;
        lat_idle = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #3;
            if (busy === 1'b0 && lat_idle == 0) lat_idle = i;
        end
        chk("err_busy_release", lat_idle, 3);
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ne = 1'b1; noe = 1'b1; nwe = 1'b1; a = '0; din = '0;
        for (int i = 0; i < 4096; i++) begin
            bufmem[i]  = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        tick(3);
        chk_reset("por");
        rst = 1'b0;
        tick(3);

        // Reset in the middle of a write strobe aborts it.
        a = 12'h010; din = 16'hA5A5; ne = 1'b0; nwe = 1'b0;
        tick(4);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk_reset("mid_reset");
        ne = 1'b1; nwe = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);

        wr(12'h123, 16'hBEEF, 6, 16'hBEEF, 0);
        chk("pin_model_123", ref_mem[12'h123], 16'hBEEF);
        rd(12'h123);

        wr(12'h045, 16'h1111, 3, 16'h2222, 3);
        chk("pin_model_045", ref_mem[12'h045], 16'h2222);
        rd(12'h045);

        proto_err();

        wr(12'h020, 16'h5A5A, 5, 16'h5A5A, 0);
        wr(12'h001, 16'h1234, 4, 16'h1234, 0);
        wr(12'h002, 16'h5678, 4, 16'h5678, 0);
        wr(12'h003, 16'h9ABC, 4, 16'h9ABC, 0);
        chk("pin_model_002", ref_mem[12'h002], 16'h5678);
        rd(12'h002);
        chk("pin_model_010", ref_mem[12'h010], 16'h0000);
        rd(12'h010);

        tick(4);
        chk("pin_small_writes", exp_small, 3);
        chk("main_write_cycles", main_lows, exp_commits);
        chk("small_write_cycles", small_lows, exp_small);
        chk("err_pulse_total", err_pulses, 1);
        chk("final_queue_empty", exp_wq.size(), 0);
`ifdef FSMC_STAT_EN
        chk("wr_count", wrc, exp_commits);
        chk("rd_count", rdc, exp_reads);
        chk("small_wr_count", s_wrc, exp_small);
        chk("small_rd_count", s_rdc, exp_reads);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
